// File: rtl/deal_pkg.sv
// Shared types and default constants for the card-deal sequencer.
package deal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EJECT  = 3'd1,
        ST_ROTATE = 3'd2,
        ST_RETURN = 3'd3,
        ST_DONE   = 3'd4
    } deal_state_e;

    localparam int STEPS_PER_SEAT_DEF = 128;
    localparam int STEP_DIV_DEF       = 16;
    localparam int EJECT_CYC_DEF      = 64;
    localparam int MAX_PEOPLE_DEF     = 4;

    // A zero seat count still deals to the dealer's own seat; oversize
    // requests are limited to the number of physical seats.
    function automatic logic [2:0] clamp_people(input logic [2:0] p, input int max_p);
        if (p == 3'd0)
            return 3'd1;
        else if (int'(p) > max_p)
            return 3'(max_p);
        else
            return p;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Step-rate strobe generator: one-cycle tick every STEP_DIV cycles while
// enabled; the first tick lands STEP_DIV cycles after a restart.
module step_timer
    import deal_pkg::*;
#(
    parameter int STEP_DIV = STEP_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic en,
    output logic tick
);

    localparam int DW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic          tick_q, tick_d;

    // Divider advance; restart wins so every motion starts on a full period.
    always_comb begin
        div_d  = div_q;
        tick_d = 1'b0;
        if (restart) begin
            div_d = '0;
        end else if (en) begin
            if (div_q == DW'(STEP_DIV - 1)) begin
                div_d  = '0;
                tick_d = 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    // Divider and registered strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/deal_sequencer.sv
// Card-deal sequencer: ejects cards seat by seat, rotating the carriage
// with a stepper between seats and returning home between rounds.
// Optional feature macro: DEAL_SEQUENCER_RETURN_HOME_EN -- when defined the
// carriage returns to seat 0 after the final card; otherwise it stays put.
module deal_sequencer
    import deal_pkg::*;
#(
    parameter int STEPS_PER_SEAT = STEPS_PER_SEAT_DEF,
    parameter int STEP_DIV       = STEP_DIV_DEF,
    parameter int EJECT_CYC      = EJECT_CYC_DEF,
    parameter int MAX_PEOPLE     = MAX_PEOPLE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [2:0] people,
    input  logic [3:0] cards,
    output logic       step_pulse,
    output logic       step_dir,
    output logic       eject_en,
    output logic       busy,
    output logic       done,
    output logic [2:0] seat
);

    // Step counter holds either pulses issued in a seat move or pulses
    // still owed on the way home; the latter peaks below MAX_PEOPLE seats.
    localparam int CNT_W = $clog2(MAX_PEOPLE * STEPS_PER_SEAT + 1);
    localparam int EJ_W  = $clog2(EJECT_CYC + 1);

    deal_state_e      state_q, state_d;
    logic [2:0]       people_q, people_d;
    logic [3:0]       rounds_q, rounds_d;
    logic [2:0]       seat_q, seat_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic [EJ_W-1:0]  eject_cnt_q, eject_cnt_d;

    logic             tick;
    logic             moving;
    logic             timer_restart;
    logic [CNT_W-1:0] home_dist;

    assign moving        = (state_q == ST_ROTATE) || (state_q == ST_RETURN);
    assign timer_restart = ((state_d == ST_ROTATE) || (state_d == ST_RETURN)) &&
                           (state_d != state_q);
    assign home_dist     = CNT_W'(seat_q) * CNT_W'(STEPS_PER_SEAT);

    step_timer #(
        .STEP_DIV (STEP_DIV)
    ) u_step_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (timer_restart),
        .en      (moving),
        .tick    (tick)
    );

    // Next-state and datapath updates for the deal sequence.
    always_comb begin
        state_d     = state_q;
        people_d    = people_q;
        rounds_d    = rounds_q;
        seat_d      = seat_q;
        step_cnt_d  = step_cnt_q;
        eject_cnt_d = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    people_d   = clamp_people(people, MAX_PEOPLE);
                    rounds_d   = cards;
                    step_cnt_d = '0;
                    state_d    = (cards == 4'd0) ? ST_DONE : ST_EJECT;
                end
            end

            ST_EJECT: begin
                if (stop) begin
                    rounds_d   = '0;
                    step_cnt_d = home_dist;
                    state_d    = ST_RETURN;
                end else if (eject_cnt_q == EJ_W'(EJECT_CYC - 1)) begin
                    if (seat_q < people_q - 3'd1) begin
                        step_cnt_d = '0;
                        state_d    = ST_ROTATE;
                    end else begin
                        // Last seat of this round has its card.
                        rounds_d   = rounds_q - 4'd1;
                        step_cnt_d = home_dist;
                        if (rounds_q > 4'd1) begin
                            state_d = ST_RETURN;
                        end else begin
`ifdef DEAL_SEQUENCER_RETURN_HOME_EN
                            state_d = ST_RETURN;
`else
                            state_d = ST_DONE;
`endif
                        end
                    end
                end else begin
                    eject_cnt_d = eject_cnt_q + 1'b1;
                end
            end

            ST_ROTATE: begin
                if (stop) begin
                    // Pulses already sent this move (including one going out
                    // now) must be undone on the way home.
                    rounds_d   = '0;
                    step_cnt_d = home_dist + step_cnt_q + CNT_W'(tick);
                    state_d    = ST_RETURN;
                end else if (tick) begin
                    if (step_cnt_q == CNT_W'(STEPS_PER_SEAT - 1)) begin
                        seat_d     = seat_q + 3'd1;
                        step_cnt_d = '0;
                        state_d    = ST_EJECT;
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                    end
                end
            end

            ST_RETURN: begin
                if (step_cnt_q == '0) begin
                    seat_d  = '0;
                    state_d = (rounds_q != 4'd0) ? ST_EJECT : ST_DONE;
                end else if (tick) begin
                    step_cnt_d = step_cnt_q - 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset parks everything with no motion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            people_q    <= 3'd1;
            rounds_q    <= '0;
            seat_q      <= '0;
            step_cnt_q  <= '0;
            eject_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            people_q    <= people_d;
            rounds_q    <= rounds_d;
            seat_q      <= seat_d;
            step_cnt_q  <= step_cnt_d;
            eject_cnt_q <= eject_cnt_d;
        end
    end

    // Outputs decode from registered state so they are mutually exclusive
    // (no pulse while ejecting) and drop as soon as reset lands.
    assign step_pulse = tick && ((state_q == ST_ROTATE) ||
                                 ((state_q == ST_RETURN) && (step_cnt_q != '0)));
    assign step_dir   = (state_q == ST_ROTATE);
    assign eject_en   = (state_q == ST_EJECT);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign seat       = seat_q;

endmodule
